// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: pipelined Wishbone decoder routing one master to memory, LED and switch slaves.
// Optional watchdog on hung slaves is enabled by defining WB_DECODE_TIMEOUT_EN.
module wb_slave_decoder #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int MEM_AW          = 18,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_s_we,
    output logic [29:0] o_s_addr,
    output logic [31:0] o_s_data,
    output logic [3:0]  o_s_sel,
    output logic        o_mem_cyc,
    output logic        o_mem_stb,
    output logic        o_led_cyc,
    output logic        o_led_stb,
    output logic        o_sw_cyc,
    output logic        o_sw_stb,
    input  logic        i_mem_ack,
    input  logic        i_mem_stall,
    input  logic        i_led_ack,
    input  logic        i_led_stall,
    input  logic        i_sw_ack,
    input  logic        i_sw_stall,
    input  logic [31:0] i_mem_data,
    input  logic [31:0] i_led_data,
    input  logic [31:0] i_sw_data
);
    typedef enum logic [1:0] {T_NONE, T_MEM, T_LED, T_SW} target_t;

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_slave_decoder: parameter out of range");
    end

    target_t     decoded;
    target_t     r_target;
    logic [3:0]  count;
    logic        req;
    logic        busy;
    logic        full;
    logic        switching;
    logic        slave_stall;
    logic        route_ok;
    logic        accept;
    logic        ack_sel;
    logic [31:0] data_sel;
    logic        dec;
    logic        err_unmapped;
    logic        err_timeout;
    logic        timeout;

    assign o_s_we   = i_wb_we;
    assign o_s_addr = i_wb_addr;
    assign o_s_data = i_wb_data;
    assign o_s_sel  = i_wb_sel;

    // address decode and per-target selection of slave responses
    always_comb begin
        decoded     = (i_wb_addr[29:MEM_AW] == '0)  ? T_MEM :
                      (i_wb_addr == 30'h3FFFFFFF)   ? T_LED :
                      (i_wb_addr == 30'h3FFFFFFE)   ? T_SW  : T_NONE;
        slave_stall = (decoded == T_MEM) ? i_mem_stall :
                      (decoded == T_LED) ? i_led_stall :
                      (decoded == T_SW)  ? i_sw_stall  : 1'b0;
        ack_sel     = (r_target == T_MEM) ? i_mem_ack :
                      (r_target == T_LED) ? i_led_ack :
                      (r_target == T_SW)  ? i_sw_ack  : 1'b0;
        data_sel    = (r_target == T_MEM) ? i_mem_data :
                      (r_target == T_LED) ? i_led_data :
                      (r_target == T_SW)  ? i_sw_data  : 32'h0;
    end

    // request routing; a new target waits until every older request has completed so acks stay ordered
    always_comb begin
        req        = i_wb_cyc & i_wb_stb;
        busy       = count != 4'd0;
        full       = count == 4'(MAX_OUTSTANDING);
        switching  = busy && (decoded != r_target);
        route_ok   = req & ~full & ~switching;
        o_wb_stall = req & (full | switching | slave_stall);
        accept     = req & ~o_wb_stall;
        o_mem_stb  = route_ok & (decoded == T_MEM);
        o_led_stb  = route_ok & (decoded == T_LED);
        o_sw_stb   = route_ok & (decoded == T_SW);
        o_mem_cyc  = i_wb_cyc & ((busy & (r_target == T_MEM)) | (i_wb_stb & (decoded == T_MEM)));
        o_led_cyc  = i_wb_cyc & ((busy & (r_target == T_LED)) | (i_wb_stb & (decoded == T_LED)));
        o_sw_cyc   = i_wb_cyc & ((busy & (r_target == T_SW))  | (i_wb_stb & (decoded == T_SW)));
        o_wb_ack   = i_wb_cyc & busy & ack_sel;
        o_wb_data  = o_wb_ack ? data_sel : 32'h0;
        o_wb_err   = i_wb_cyc & (err_unmapped | err_timeout);
        dec        = busy & (o_wb_ack | err_unmapped);
    end

    // outstanding count, current target and the unmapped-access error pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count        <= 4'd0;
            r_target     <= T_NONE;
            err_unmapped <= 1'b0;
        end else if (!i_wb_cyc) begin
            count        <= 4'd0;
            r_target     <= T_NONE;
            err_unmapped <= 1'b0;
        end else if (timeout) begin
            count        <= accept ? 4'd1 : 4'd0;
            r_target     <= accept ? decoded : T_NONE;
            err_unmapped <= accept && (decoded == T_NONE);
        end else begin
            count        <= count + 4'(accept) - 4'(dec);
            r_target     <= accept ? decoded : r_target;
            err_unmapped <= accept && (decoded == T_NONE);
        end
    end

`ifdef WB_DECODE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd;

    assign timeout = busy && !o_wb_ack && !o_wb_err && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    // watchdog: counts stalled cycles while requests are outstanding; fires once and abandons them
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= i_wb_cyc & timeout;
            wd          <= (!i_wb_cyc || !busy || o_wb_ack || o_wb_err || timeout) ? '0 : wd + 1'b1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb_wb_slave_decoder: directed checks of decode, routing, ordering, errors, cyc drop, reset and watchdog.
module tb_wb_slave_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = 4'hF;
    logic        ack, err, stall;
    logic [31:0] rdata;
    logic        s_we;
    logic [29:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_sel;
    logic        mem_cyc, mem_stb, led_cyc, led_stb, sw_cyc, sw_stb;
    logic        mem_ack = 1'b0, mem_stall = 1'b0;
    logic        led_ack = 1'b0, led_stall = 1'b0;
    logic        sw_ack = 1'b0, sw_stall = 1'b0;
    logic [31:0] mem_data = '0, led_data = '0, sw_data = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    wb_slave_decoder #(.MAX_OUTSTANDING(4), .MEM_AW(18), .TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_ack(ack), .o_wb_err(err), .o_wb_stall(stall), .o_wb_data(rdata),
        .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_data), .o_s_sel(s_sel),
        .o_mem_cyc(mem_cyc), .o_mem_stb(mem_stb),
        .o_led_cyc(led_cyc), .o_led_stb(led_stb),
        .o_sw_cyc(sw_cyc), .o_sw_stb(sw_stb),
        .i_mem_ack(mem_ack), .i_mem_stall(mem_stall),
        .i_led_ack(led_ack), .i_led_stall(led_stall),
        .i_sw_ack(sw_ack), .i_sw_stall(sw_stall),
        .i_mem_data(mem_data), .i_led_data(led_data), .i_sw_data(sw_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [29:0] a, input logic [31:0] d);
        stb = 1'b1; we = w; addr = a; wdata = d;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mem_cyc", mem_cyc, 0);
        cyc = 1'b1;
        #1;
        chk("rst_cyc_only_mem_cyc", mem_cyc, 0);
        tick; rst = 1'b0; tick;

        req(1'b1, 30'h10, 32'hDEADBEEF);
        chk("t1_mem_stb", mem_stb, 1);
        chk("t1_led_stb", led_stb, 0);
        chk("t1_stall", stall, 0);
        chk("t1_s_data", s_data, 32'hDEADBEEF);
        chk("t1_s_we", s_we, 1);
        chk("t1_s_addr", s_addr, 32'h10);
        tick; stb = 1'b0; #1;
        chk("t1_mem_cyc_held", mem_cyc, 1);
        chk("t1_no_early_ack", ack, 0);
        mem_ack = 1'b1; #1;
        chk("t1_wr_ack", ack, 1);
        tick; mem_ack = 1'b0;
        req(1'b0, 30'h10, 32'h0);
        chk("t1_rd_mem_stb", mem_stb, 1);
        tick; stb = 1'b0;
        mem_ack = 1'b1; mem_data = 32'hDEADBEEF;
        led_ack = 1'b1; led_data = 32'h12345678;
        #1;
        chk("t1_rd_ack", ack, 1);
        chk("t1_rd_data", rdata, 32'hDEADBEEF);
        tick; mem_ack = 1'b0; led_ack = 1'b0; #1;
        chk("t1_idle_ack", ack, 0);
        chk("t1_idle_data", rdata, 0);
        chk("t1_idle_mem_cyc", mem_cyc, 0);

        req(1'b1, 30'h3FFFFFFF, 32'h0000A5A5);
        chk("t2_led_stb", led_stb, 1);
        chk("t2_mem_stb", mem_stb, 0);
        chk("t2_sw_stb", sw_stb, 0);
        chk("t2_sw_cyc", sw_cyc, 0);
        tick; stb = 1'b0; #1;
        chk("t2_led_stb_once", led_stb, 0);
        chk("t2_led_cyc", led_cyc, 1);
        mem_ack = 1'b1; #1;
        chk("t2_foreign_ack", ack, 0);
        mem_ack = 1'b0; led_ack = 1'b1; #1;
        chk("t2_led_ack", ack, 1);
        tick; led_ack = 1'b0;

        req(1'b0, 30'h20, 32'h0);
        chk("t3_mem_stb", mem_stb, 1);
        tick;
        req(1'b1, 30'h3FFFFFFF, 32'h5);
        chk("t3_stall", stall, 1);
        chk("t3_led_stb", led_stb, 0);
        chk("t3_led_cyc", led_cyc, 1);
        chk("t3_mem_cyc", mem_cyc, 1);
        tick; #1;
        chk("t3_stall2", stall, 1);
        tick; mem_ack = 1'b1; mem_data = 32'h00000020; #1;
        chk("t3_mem_ack", ack, 1);
        chk("t3_mem_data", rdata, 32'h20);
        chk("t3_stall_on_ack", stall, 1);
        tick; mem_ack = 1'b0; #1;
        chk("t3_stall_clear", stall, 0);
        chk("t3_led_stb_go", led_stb, 1);
        tick; stb = 1'b0; led_ack = 1'b1; #1;
        chk("t3_led_ack", ack, 1);
        chk("t3_led_data", rdata, 32'h12345678);
        tick; led_ack = 1'b0; #1;
        chk("t3_led_cyc_idle", led_cyc, 0);

        req(1'b0, 30'h00040000, 32'h0);
        chk("t4_mem_stb", mem_stb, 0);
        chk("t4_led_stb", led_stb, 0);
        chk("t4_sw_stb", sw_stb, 0);
        chk("t4_mem_cyc", mem_cyc, 0);
        chk("t4_stall", stall, 0);
        chk("t4_err_before", err, 0);
        tick; stb = 1'b0; #1;
        chk("t4_err", err, 1);
        chk("t4_ack", ack, 0);
        req(1'b0, 30'h40, 32'h0);
        chk("t4_pending_stall", stall, 1);
        stb = 1'b0;
        tick; #1;
        chk("t4_err_gone", err, 0);
        chk("t4_ack_after", ack, 0);
        req(1'b0, 30'h40, 32'h0);
        chk("t4_count_zero", stall, 0);
        stb = 1'b0; #1;

        req(1'b0, 30'h30, 32'h0);
        tick;
        req(1'b0, 30'h31, 32'h0);
        chk("t5_second_nostall", stall, 0);
        tick; stb = 1'b0; #1;
        chk("t5_mem_cyc", mem_cyc, 1);
        cyc = 1'b0; mem_ack = 1'b1; #1;
        chk("t5_drop_mem_cyc", mem_cyc, 0);
        chk("t5_drop_ack", ack, 0);
        tick; cyc = 1'b1; #1;
        chk("t5_stray_ack", ack, 0);
        chk("t5_mem_cyc_after", mem_cyc, 0);
        mem_ack = 1'b0;
        req(1'b0, 30'h30, 32'h0);
        tick; stb = 1'b0; #1;
        chk("t5_pre_reset_cyc", mem_cyc, 1);
        rst = 1'b1; #1;
        chk("t5_reset_mem_cyc", mem_cyc, 0);
        mem_ack = 1'b1; #1;
        chk("t5_reset_ack", ack, 0);
        tick; rst = 1'b0; tick;
        chk("t5_post_reset_ack", ack, 0);
        mem_ack = 1'b0;

        req(1'b1, 30'h3FFFFFFF, 32'h1);
        tick; stb = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick;
`ifdef WB_DECODE_TIMEOUT_EN
            chk($sformatf("t6_err_c%0d", k), err, 32'(k == 16));
`else
            chk($sformatf("t6_err_c%0d", k), err, 0);
`endif
        end
`ifdef WB_DECODE_TIMEOUT_EN
        chk("t6_led_cyc_abandoned", led_cyc, 0);
        led_ack = 1'b1; #1;
        chk("t6_late_ack", ack, 0);
        led_ack = 1'b0;
`else
        chk("t6_led_cyc_hung", led_cyc, 1);
`endif
        cyc = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
